// File: rtl/q_episode_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// q_episode_sequencer
// Runs one exploit episode of the 6x6 maze Q-learning agent.
// Each step has four parts:
//   1. Read the four Q values of the current state.
//   2. Pick the greedy action, using a signed argmax where ties go to the
//      lowest action.
//   3. Hand the action to the move datapath over mv_req/mv_ack.
//   4. Latch the returned state.
// The episode stops when the target is reached or the step budget is spent.
//
// Optional feature: define Q_EXPLORE_EN to add a 16-bit Galois LFSR.
//   - When lfsr[7:0] < EPS_THRESH, the chosen action is lfsr[9:8].
//   - The EPS_THRESH parameter exists only in that build.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             episode start level (sampled in IDLE and DONE)
//   start_state     episode start state (sampled in LOAD)
//   target_state    goal state (stable while busy)
//   q_rd_en/q_rd_state/q_rd_action/q_rd_data
//                   Q-table read port, with 1-cycle read latency
//   mv_req/mv_action/mv_ack/mv_state
//                   move datapath handshake
//   cur_state, busy, target_reached, timeout, step_count, episode_count
//                   episode status
// ---------------------------------------------------------------------------
module q_episode_sequencer #(
    parameter int Q_W        = 32,
    parameter int STATE_W    = 6,
    parameter int NUM_STATES = 36,
    parameter int MAX_STEPS  = 64,
    parameter int STEP_W     = 7
`ifdef Q_EXPLORE_EN
    ,
    parameter int EPS_THRESH = 26
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [STATE_W-1:0] start_state,
    input  logic [STATE_W-1:0] target_state,
    output logic               q_rd_en,
    output logic [STATE_W-1:0] q_rd_state,
    output logic [1:0]         q_rd_action,
    input  logic [Q_W-1:0]     q_rd_data,
    output logic               mv_req,
    output logic [1:0]         mv_action,
    input  logic               mv_ack,
    input  logic [STATE_W-1:0] mv_state,
    output logic [STATE_W-1:0] cur_state,
    output logic               busy,
    output logic               target_reached,
    output logic               timeout,
    output logic [STEP_W-1:0]  step_count,
    output logic [15:0]        episode_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READ, S_DRAIN, S_MOVE, S_CHECK, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]            rd_idx;
    logic                  rd_vld_p1;
    logic [1:0]            rd_act_p1;
    logic signed [Q_W-1:0] q_word_p1;
    logic signed [Q_W-1:0] best_q_p1;
    logic [1:0]            best_act_p1;
    logic                  take_word;
    logic [1:0]            greedy_act;
    logic [1:0]            act_pick;
    logic                  start_hit;
    logic                  budget_spent;

    // Legal maze states are 1..NUM_STATES; 0 and anything above are off-board.
    function automatic logic state_ok(input logic [STATE_W-1:0] s);
        return (s != '0) && (int'(s) <= NUM_STATES);
    endfunction

    assign start_hit    = (start_state == target_state);
    assign budget_spent = (step_count == STEP_W'(MAX_STEPS));

    // ---- control: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_LOAD;
            S_LOAD:  if (start_hit || !state_ok(start_state)) state_nxt = S_DONE;
                     else state_nxt = S_READ;
            S_READ:  if (rd_idx == 2'd3) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_MOVE;
            S_MOVE:  if (mv_ack) state_nxt = S_CHECK;
            S_CHECK: if ((cur_state == target_state) || budget_spent) state_nxt = S_DONE;
                     else state_nxt = S_READ;
            S_DONE:  if (!run) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign q_rd_en     = (state == S_READ);
    assign q_rd_state  = cur_state;
    assign q_rd_action = rd_idx;
    assign mv_req      = (state == S_MOVE);
    assign busy        = (state != S_IDLE) && (state != S_DONE);

    // ---- stage p1: read word returns one cycle after its strobe ----
    assign q_word_p1 = q_rd_data;

    // The action-0 word always seeds the running best; later words replace it
    // only when strictly greater, which leaves ties on the lower action.
    assign take_word  = rd_vld_p1 && ((rd_act_p1 == 2'd0) || (q_word_p1 > best_q_p1));
    assign greedy_act = take_word ? rd_act_p1 : best_act_p1;

    always_ff @(posedge clk) begin
        if (take_word) best_q_p1 <= q_word_p1;
    end

`ifdef Q_EXPLORE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign act_pick = (32'(lfsr[7:0]) < EPS_THRESH) ? lfsr[9:8] : greedy_act;
`else
    assign act_pick = greedy_act;
`endif

    // ---- control: episode bookkeeping ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx         <= 2'd0;
            rd_vld_p1      <= 1'b0;
            rd_act_p1      <= 2'd0;
            best_act_p1    <= 2'd0;
            mv_action      <= 2'd0;
            cur_state      <= '0;
            step_count     <= '0;
            target_reached <= 1'b0;
            timeout        <= 1'b0;
            episode_count  <= 16'd0;
        end else begin
            rd_vld_p1 <= q_rd_en;
            rd_act_p1 <= rd_idx;
            rd_idx    <= (state == S_READ) ? rd_idx + 2'd1 : 2'd0;
            if (take_word) best_act_p1 <= rd_act_p1;

            case (state)
                S_LOAD: begin
                    cur_state      <= start_state;
                    step_count     <= '0;
                    target_reached <= start_hit;
                    timeout        <= !start_hit && !state_ok(start_state);
                end
                S_DRAIN: mv_action <= act_pick;
                S_MOVE: begin
                    if (mv_ack) begin
                        step_count <= step_count + 1'b1;
                        // An off-board result still burns a step but leaves the agent in place.
                        if (state_ok(mv_state)) cur_state <= mv_state;
                    end
                end
                S_CHECK: begin
                    if (cur_state == target_state) target_reached <= 1'b1;
                    else if (budget_spent)          timeout        <= 1'b1;
                end
                default: ;
            endcase

            if ((state_nxt == S_DONE) && (state != S_DONE))
                episode_count <= episode_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_q_episode_sequencer.sv
`timescale 1ns/1ps
module tb_q_episode_sequencer;

    localparam int Q_W        = 32;
    localparam int STATE_W    = 6;
    localparam int NUM_STATES = 36;
    localparam int MAX_STEPS  = 4;
    localparam int STEP_W     = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic [STATE_W-1:0] start_state;
    logic [STATE_W-1:0] target_state;
    logic               q_rd_en;
    logic [STATE_W-1:0] q_rd_state;
    logic [1:0]         q_rd_action;
    logic [Q_W-1:0]     q_rd_data = '0;
    logic               mv_req;
    logic [1:0]         mv_action;
    logic               mv_ack;
    logic [STATE_W-1:0] mv_state;
    logic [STATE_W-1:0] cur_state;
    logic               busy;
    logic               target_reached;
    logic               timeout;
    logic [STEP_W-1:0]  step_count;
    logic [15:0]        episode_count;

    always #5 clk = ~clk;

    q_episode_sequencer #(
        .Q_W(Q_W), .STATE_W(STATE_W), .NUM_STATES(NUM_STATES),
        .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .start_state(start_state), .target_state(target_state),
        .q_rd_en(q_rd_en), .q_rd_state(q_rd_state), .q_rd_action(q_rd_action),
        .q_rd_data(q_rd_data),
        .mv_req(mv_req), .mv_action(mv_action), .mv_ack(mv_ack), .mv_state(mv_state),
        .cur_state(cur_state), .busy(busy), .target_reached(target_reached),
        .timeout(timeout), .step_count(step_count), .episode_count(episode_count)
    );

    typedef struct { int act; int len; } act_t;
    typedef struct { int st;  int dly; } resp_t;
    typedef struct { int tr; int to; int steps; int cur; int epc; } end_t;

    act_t  act_q[$];
    resp_t resp_q[$];
    end_t  end_q[$];

    int qtab [0:63][0:3];
    int total = 0;
    int bad = 0;
    int model_epc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Q-table RAM: data for a strobe appears on the following cycle
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qtab[q_rd_state][q_rd_action];
    end

    // Move datapath: replays the responses planned by the reference model
    initial begin
        resp_t r;
        mv_ack   = 1'b0;
        mv_state = '0;
        forever begin
            @(negedge clk);
            if (!rst && mv_req && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (r.dly) @(negedge clk);
                mv_ack   = 1'b1;
                mv_state = STATE_W'(r.st);
                @(negedge clk);
                mv_ack   = 1'b0;
                mv_state = '0;
            end
        end
    end

    // Monitor / scoreboard
    int   cyc = 0;
    int   rd_rise_cyc = 0;
    int   rd_idx = 0;
    int   req_len = 0;
    int   rd_total = 0;
    int   req_total = 0;
    logic prev_req = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_rd = 1'b0;
    act_t cur_exp;

    always @(negedge clk) begin
        end_t e;
        cyc++;
        if (!rst) begin
            if (q_rd_en) begin
                rd_total++;
                if (!prev_rd) begin
                    rd_idx = 0;
                    rd_rise_cyc = cyc;
                end else begin
                    rd_idx++;
                end
                check("rd_action", q_rd_action, rd_idx);
            end
            if (mv_req && !prev_req) begin
                req_total++;
                req_len = 1;
                check("sel_latency", cyc - rd_rise_cyc, 5);
                if (act_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got action %0d expected no request", mv_action);
                    cur_exp.act = -1; cur_exp.len = -1;
                end else begin
                    cur_exp = act_q.pop_front();
                    check("mv_action", mv_action, cur_exp.act);
                end
            end else if (mv_req) begin
                req_len++;
                if (cur_exp.act >= 0) check("action_stable", mv_action, cur_exp.act);
            end else if (prev_req && cur_exp.len >= 0) begin
                check("req_len", req_len, cur_exp.len);
            end
            if (!busy && prev_busy) begin
                if (end_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got step_count %0d expected no episode end", step_count);
                end else begin
                    e = end_q.pop_front();
                    check("target_reached", target_reached, e.tr);
                    check("timeout", timeout, e.to);
                    check("step_count", step_count, e.steps);
                    check("cur_state", cur_state, e.cur);
                    check("episode_count", episode_count, e.epc);
                end
            end
        end
        prev_req  = mv_req;
        prev_busy = busy;
        prev_rd   = q_rd_en;
    end

    // ---------------- reference model ----------------
    function automatic int greedy(input int s);
        int mx = qtab[s][0];
        for (int a = 1; a < 4; a++) if (qtab[s][a] > mx) mx = qtab[s][a];
        for (int a = 0; a < 4; a++) if (qtab[s][a] == mx) return a;
        return 0;
    endfunction

    function automatic int rand_q();
        int k = int'($urandom_range(0, 15));
        if (k == 0) return int'(32'h7fffffff);
        if (k == 1) return int'(32'h80000000);
        return int'($urandom_range(0, 6)) - 3;
    endfunction

    function automatic int rand_resp(input int cur, input int target);
        int k = int'($urandom_range(0, 15));
        if (k < 4)  return target;
        if (k == 4) return 0;
        if (k == 5) return int'($urandom_range(37, 63));
        if (k < 8)  return cur;
        return int'($urandom_range(1, NUM_STATES));
    endfunction

    // mode 0: random responses, 1: echo current state, 2: always return target
    // fdly < 0 picks a random ack delay per move
    task automatic plan(input int start, input int target, input int mode, input int fdly);
        int cur = start;
        int steps = 0;
        int tr = 0;
        int to = 0;
        int d, r;
        act_t  a;
        resp_t rs;
        end_t  e;
        start_state  = STATE_W'(start);
        target_state = STATE_W'(target);
        if (start == target) tr = 1;
        else if (start < 1 || start > NUM_STATES) to = 1;
        else begin
            while (tr == 0 && to == 0) begin
                d = (fdly >= 0) ? fdly : int'($urandom_range(0, 3));
                a.act = greedy(cur);
                a.len = d + 1;      // request stays up through the ack cycle
                act_q.push_back(a);
                case (mode)
                    1:       r = cur;
                    2:       r = target;
                    default: r = rand_resp(cur, target);
                endcase
                rs.st = r; rs.dly = d;
                resp_q.push_back(rs);
                if (r >= 1 && r <= NUM_STATES) cur = r;
                steps++;
                if (cur == target) tr = 1;
                else if (steps == MAX_STEPS) to = 1;
            end
        end
        model_epc = (model_epc + 1) % 65536;
        e.tr = tr; e.to = to; e.steps = steps; e.cur = cur; e.epc = model_epc;
        end_q.push_back(e);
    endtask

    task automatic flush_and_reset();
        act_q.delete(); resp_q.delete(); end_q.delete();
        @(posedge clk); #2 rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_epc = 0;
        repeat (15) @(negedge clk);
    endtask

    task automatic run_ep(input int start, input int target, input int mode,
                          input int fdly, input bit early_drop);
        plan(start, target, mode, fdly);
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        if (early_drop) run = 1'b0;
        for (int i = 0; i < 800 && end_q.size() > 0; i++) @(negedge clk);
        if (end_q.size() > 0) begin
            total++; bad++;
            $display("FAIL episode_end: got %0d pending episodes expected 0", end_q.size());
            flush_and_reset();
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic randomize_q();
        for (int s = 0; s < 64; s++)
            for (int a = 0; a < 4; a++) qtab[s][a] = rand_q();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, rq0, tgt, st, k;
        rst = 1'b1;
        run = 1'b0;
        start_state  = '0;
        target_state = '0;
        randomize_q();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_mv_req", mv_req, 0);
        check("rst_q_rd_en", q_rd_en, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("init_cur_state", cur_state, 0);
        check("init_step_count", step_count, 0);
        check("init_episode_count", episode_count, 0);
        check("init_flags", {target_reached, timeout}, 0);
        check("init_mv_action", mv_action, 0);

        // Tie between actions 1 and 2 resolves to 1; one move reaches the target
        qtab[1][0] = 5; qtab[1][1] = 9; qtab[1][2] = 9; qtab[1][3] = -3;
        run_ep(1, 7, 2, 0, 0);
        check("t1_action", mv_action, 1);
        check("t1_steps", step_count, 1);
        check("t1_target", target_reached, 1);
        check("t1_epc", episode_count, 1);

        // All-equal Q values, agent never moves: budget runs out
        for (int s = 0; s < 64; s++) for (int a = 0; a < 4; a++) qtab[s][a] = -1;
        run_ep(10, 30, 1, 0, 0);
        check("t2_timeout", timeout, 1);
        check("t2_target", target_reached, 0);
        check("t2_steps", step_count, MAX_STEPS);

        // Start already on target: DONE two cycles after run rises
        plan(20, 20, 0, -1);
        rd0 = rd_total; rq0 = req_total;
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1 check("t3_busy_load", busy, 1);
        @(posedge clk); #1 check("t3_done_target", target_reached, 1);
        check("t3_done_busy", busy, 0);
        check("t3_steps", step_count, 0);
        repeat (3) @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_no_reads", rd_total - rd0, 0);
        check("t3_no_reqs", req_total - rq0, 0);

        // Long ack delay: request held, action stable (checked by the monitor)
        randomize_q();
        run_ep(5, 33, 0, 10, 0);

        // Asynchronous reset in the middle of a move
        plan(3, 35, 0, 10);
        @(negedge clk); run = 1'b1;
        for (int i = 0; i < 50 && !mv_req; i++) @(negedge clk);
        check("t5_reached_move", mv_req, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_mv_req", mv_req, 0);
        check("t5_busy", busy, 0);
        check("t5_rd_en", q_rd_en, 0);
        check("t5_step_count", step_count, 0);
        check("t5_episode_count", episode_count, 0);
        check("t5_cur_state", cur_state, 0);
        run = 1'b0;
        act_q.delete(); end_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_epc = 0;
        // the pending ack arrives while idle and must be ignored
        repeat (15) @(negedge clk);
        resp_q.delete();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_cur", cur_state, 0);
        check("t5_idle_steps", step_count, 0);

        // Randomized episodes
        for (int n = 0; n < 40; n++) begin
            randomize_q();
            tgt = int'($urandom_range(1, NUM_STATES));
            k = int'($urandom_range(0, 7));
            if (k == 0)      st = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(37, 63));
            else if (k == 1) st = tgt;
            else             st = int'($urandom_range(1, NUM_STATES));
            run_ep(st, tgt, 0, -1, $urandom_range(0, 3) == 0);
        end

        check("final_act_q_empty", act_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
